// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit_if
// Brief   : Instruction-memory request/response bundle between the fetch
//           stage (master) and instruction memory (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_valid;

  // Fetch stage drives the request, memory answers with data/valid.
  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction-fetch stage. Owns PC and IR, fetches one word per
//           instruction over a wait-state tolerant handshake, decodes the IR
//           fields and applies the control unit's jump/branch decision.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire               clk,
  input  wire               reset,        // active-low, synchronous
  fetch_unit_if.master      imem,
  input  wire               jump,
  input  wire               take_branch,
  input  wire               stall,
  output logic              phase,
  output logic              instr_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  // Encoding matches the control unit's phase signal: 0 = fetch, 1 = execute.
  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   imm_sext;
  logic [ADDR_W-1:0]   imm_zext;
  logic [ADDR_W-1:0]   pc_inc;

  // The immediate is 16 bits; adapt it to the PC width. Narrower PCs simply
  // keep the low bits, which gives the same result modulo 2^ADDR_W.
  generate
    if (ADDR_W > 16) begin : g_wide_pc
      assign imm_sext = {{(ADDR_W-16){imm[15]}}, imm};
      assign imm_zext = {{(ADDR_W-16){1'b0}}, imm};
    end else begin : g_narrow_pc
      assign imm_sext = imm[ADDR_W-1:0];
      assign imm_zext = imm[ADDR_W-1:0];
    end
  endgenerate

  // Field decode and status outputs come straight off the state/IR/PC flops.
  always_comb begin
    pc_inc          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    opcode          = ir_q[31:28];
    rd              = ir_q[27:24];
    rs              = ir_q[23:20];
    rt              = ir_q[19:16];
    imm             = ir_q[15:0];
    pc              = pc_q;
    pc_plus1        = pc_inc;
    phase           = (state_q == S_EXEC);
    instr_valid     = (state_q == S_EXEC);
    imem.imem_rd    = (state_q == S_FETCH);
    imem.imem_addr  = pc_q;
  end

  // Next-state logic: wait for the memory word in FETCH, then hold in EXEC
  // while stalled and resolve the next PC (jump beats branch beats +1).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (jump) begin
            pc_d = imm_zext;
          end else if (take_branch) begin
            pc_d = pc_inc + imm_sext;
          end else begin
            pc_d = pc_inc;
          end
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers; reset restarts fetch at RESET_PC and drops any
  // in-flight response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit with a cycle-level reference
//           model and directed plus randomized stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump, take_branch, stall;
  logic        phase, instr_valid;
  logic [3:0]  opcode, rd, rs, rt;
  logic [15:0] imm, pc, pc_plus1;

  fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) imem_bus ();

  fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .jump        (jump),
    .take_branch (take_branch),
    .stall       (stall),
    .phase       (phase),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .pc          (pc),
    .pc_plus1    (pc_plus1)
  );

  always #5 clk = ~clk;

  // Instruction memory contents, owned by the bench.
  logic [31:0] mem [0:65535];

  // Reference model: architectural view (executing?, PC, IR).
  bit          m_known = 1'b0;
  bit          m_exec;
  logic [15:0] m_pc;
  logic [31:0] m_ir;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle: compare outputs to the model, drive inputs, then
  // advance the model by the rules of the fetch stage.
  task automatic step(input bit rst_n, input bit vld, input bit jmp, input bit br, input bit stl);
    logic [15:0] m_imm;
    int          tgt;
    @(negedge clk);
    if (m_known) begin
      check("phase",       {31'b0, phase},              {31'b0, m_exec});
      check("instr_valid", {31'b0, instr_valid},        {31'b0, m_exec});
      check("imem_rd",     {31'b0, imem_bus.imem_rd},   {31'b0, !m_exec});
      check("pc",          {16'b0, pc},                 {16'b0, m_pc});
      check("imem_addr",   {16'b0, imem_bus.imem_addr}, {16'b0, m_pc});
      check("pc_plus1",    {16'b0, pc_plus1},           {16'b0, 16'(m_pc + 16'd1)});
      check("opcode",      {28'b0, opcode},             {28'b0, m_ir[31:28]});
      check("rd",          {28'b0, rd},                 {28'b0, m_ir[27:24]});
      check("rs",          {28'b0, rs},                 {28'b0, m_ir[23:20]});
      check("rt",          {28'b0, rt},                 {28'b0, m_ir[19:16]});
      check("imm",         {16'b0, imm},                {16'b0, m_ir[15:0]});
    end
    reset                = rst_n;
    imem_bus.imem_valid  = vld;
    imem_bus.imem_rdata  = (vld && !m_exec) ? mem[m_pc] : $urandom;
    jump                 = jmp;
    take_branch          = br;
    stall                = stl;
    if (!rst_n) begin
      m_known = 1'b1;
      m_exec  = 1'b0;
      m_pc    = RESET_PC;
      m_ir    = '0;
    end else if (!m_exec) begin
      if (vld) begin
        m_ir   = mem[m_pc];
        m_exec = 1'b1;
      end
    end else if (!stl) begin
      m_imm = m_ir[15:0];
      if (jmp) begin
        tgt = int'(m_imm);
      end else if (br) begin
        tgt = int'(m_pc) + 1 + int'($signed(m_imm));
      end else begin
        tgt = int'(m_pc) + 1;
      end
      m_pc   = 16'(((tgt % 65536) + 65536) % 65536);
      m_exec = 1'b0;
    end
  endtask

  // Place 'word' at the address about to be fetched, fetch it after
  // 'waits' idle cycles, stall 'stalls' cycles (with noise on jump/branch),
  // then release with the given jump/branch decision.
  task automatic run_instr(input logic [31:0] word, input int waits, input bit jmp,
                           input bit br, input int stalls);
    mem[m_pc] = word;
    for (int i = 0; i < waits; i++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < stalls; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    step(1'b1, 1'b0, jmp, br, 1'b0);
  endtask

  initial begin
    reset = 1'b0; jump = 1'b0; take_branch = 1'b0; stall = 1'b0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = '0;
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;

    // Reset, then zero-wait fetches of 0x41230000 and 0x00000000.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_instr(32'h4123_0000, 0, 1'b0, 1'b0, 0);
    run_instr(32'h0000_0000, 0, 1'b0, 1'b0, 0);

    // Branches and jump priority around pc=0x0010.
    run_instr(32'h0000_0010, 0, 1'b1, 1'b0, 0);
    run_instr(32'h0000_FFFC, 0, 1'b0, 1'b1, 0);
    run_instr(32'h0000_0010, 1, 1'b1, 1'b0, 0);
    run_instr(32'h0000_0003, 0, 1'b0, 1'b1, 0);
    run_instr(32'h0000_0200, 0, 1'b1, 1'b1, 0);

    // Three wait states at pc=5.
    run_instr(32'h0000_0005, 0, 1'b1, 1'b0, 0);
    run_instr($urandom, 3, 1'b0, 1'b0, 0);

    // PC wrap-around and wrapping branch.
    run_instr(32'h0000_FFFF, 0, 1'b1, 1'b0, 0);
    run_instr($urandom, 0, 1'b0, 1'b0, 0);
    run_instr(32'h0000_FFFE, 0, 1'b1, 1'b0, 0);
    run_instr(32'h0000_0005, 0, 1'b0, 1'b1, 0);

    // Four stall cycles with jump/branch noise, released sequentially.
    run_instr($urandom, 0, 1'b0, 1'b0, 4);

    // Reset during a memory wait at pc=0x0033, stale valid afterwards.
    run_instr(32'h0000_0033, 0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 79) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));

    // Final cycle so the last update is also compared.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
